// File: rtl/seq_right_shift.sv
// Multi-cycle right shifter: rotate/logical/arithmetic/fill right shift, one
// binary stage (1,2,4,...) per clock behind a start/busy/done handshake.
module seq_right_shift #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [1:0]   Op,
  input  logic         Fill,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STG  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [C-1:0] stg_q, stg_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic [1:0]   op_q, op_d;
  logic         fill_q, fill_d;
  logic [N-1:0] work_q, work_d;
  logic [N-1:0] out_q, out_d;

  logic                stage_en;
  logic [N-1:0]        shifted;
  logic                accept;
  logic                fillbit;
  logic [C-1:0][N-1:0] stage_res;

  // One fixed-distance candidate per stage; only the active stage's is used.
  for (genvar k = 0; k < C; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage_res[k] = (op_q == 2'b00) ? {work_q[SH-1:0], work_q[N-1:SH]}
                                          : {{SH{fill_q}}, work_q[N-1:SH]};
  end

  assign stage_en = cnt_q[stg_q];
  assign shifted  = stage_en ? stage_res[stg_q] : work_q;
  assign accept   = start && (state_q != S_STG);

  always_comb begin
    case (Op)
      2'b10:   fillbit = In[N-1];
      2'b11:   fillbit = Fill;
      default: fillbit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      S_STG: begin
        work_d = shifted;
        if (stg_q == C'(C-1)) begin
          state_d = S_DONE;
          stg_d   = '0;
          out_d   = shifted;
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        if (accept) begin
          state_d = S_STG;
          stg_d   = '0;
          work_d  = In;
          cnt_d   = Cnt;
          op_d    = Op;
          fill_d  = fillbit;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stg_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q == S_STG);
  assign done = (state_q == S_DONE);
  assign Out  = out_q;

endmodule

// File: tb/tb_seq_right_shift.sv
// Bench for seq_right_shift: directed literal cases plus random traffic, all
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_seq_right_shift;
  localparam int N = 16;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] In = '0;
  logic [C-1:0] Cnt = '0;
  logic [1:0]   Op = '0;
  logic         Fill = 1'b0;
  logic         busy, done;
  logic [N-1:0] Out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seq_right_shift #(.N(N), .C(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .In(In), .Cnt(Cnt),
    .Op(Op), .Fill(Fill), .busy(busy), .done(done), .Out(Out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int c,
                                             input logic [1:0] op, input logic f);
    logic [2*N-1:0] d;
    logic [N-1:0] ones;
    d = {x, x};
    ones = '1;
    case (op)
      2'b00:   return N'(d >> c);
      2'b01:   return x >> c;
      2'b10:   return N'($signed(x) >>> c);
      default: return (x >> c) | (f ? ~(ones >> c) : '0);
    endcase
  endfunction

  // Reference: remaining busy cycles plus the pending result.
  int           m_rem = 0;
  logic         m_done = 1'b0;
  logic [N-1:0] m_out = '0;
  logic [N-1:0] m_pend = '0;
  logic         m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 1'b0; m_out = '0;
    end else begin
      m_acc  = start && (m_rem == 0);
      m_done = (m_rem == 1);
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_out = m_pend;
      end
      if (m_acc) begin
        m_pend = ref_shift(In, int'(Cnt), Op, Fill);
        m_rem  = C;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_rem != 0));
      check("done", 32'(done), 32'(m_done));
      check("Out", 32'(Out), 32'(m_out));
      check("busy_done_excl", 32'(busy && done), 32'd0);
    end
  end

  int t0;

  task automatic wait_idle();
    @(posedge clk); #2;
    for (int i = 0; i < 20 && m_rem != 0; i++) begin
      @(posedge clk); #2;
    end
  endtask

  // Drive a request; returns at start-edge+2 with inputs scrambled.
  task automatic launch(input logic [N-1:0] in, input logic [C-1:0] c,
                        input logic [1:0] op, input logic f, input bit inject);
    start = 1'b1; In = in; Cnt = c; Op = op; Fill = f;
    @(posedge clk); t0 = cyc + 1; #2;
    start = 1'b0; In = N'($urandom); Cnt = C'($urandom); Op = 2'($urandom); Fill = 1'($urandom);
    if (inject) begin
      @(posedge clk); #2;
      start = 1'b1; In = 16'hFFFF; Op = 2'b01; Cnt = 4'd1;
      @(posedge clk); #2;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input logic [N-1:0] exp, input string nm);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({nm, "_seen"}, 32'(seen), 32'd1);
    check({nm, "_lat"}, 32'(cyc - t0), 32'(C));
    check(nm, 32'(Out), 32'(exp));
  endtask

  task automatic do_op(input logic [N-1:0] in, input logic [C-1:0] c, input logic [1:0] op,
                       input logic f, input logic [N-1:0] exp, input string nm, input bit inject);
    wait_idle();
    launch(in, c, op, f, inject);
    wait_done(exp, nm);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(Out), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    do_op(16'h8001, 4'd4,  2'b01, 1'b0, 16'h0800, "lsr_8001_4", 0);
    do_op(16'h8000, 4'd15, 2'b10, 1'b0, 16'hFFFF, "asr_8000_15", 0);
    do_op(16'h7FF0, 4'd4,  2'b10, 1'b0, 16'h07FF, "asr_7ff0_4", 0);
    do_op(16'h0001, 4'd1,  2'b00, 1'b0, 16'h8000, "ror_0001_1", 0);
    do_op(16'hA5A5, 4'd0,  2'b00, 1'b0, 16'hA5A5, "ror_a5a5_0", 0);
    do_op(16'h1234, 4'd8,  2'b00, 1'b0, 16'h3412, "ror_1234_8", 0);
    do_op(16'h0000, 4'd8,  2'b11, 1'b1, 16'hFF00, "fill1_8", 0);
    do_op(16'hFFFF, 4'd12, 2'b11, 1'b0, 16'h000F, "fill0_12", 0);
    do_op(16'h1234, 4'd8,  2'b00, 1'b0, 16'h3412, "ignore_start", 1);

    // New request held in the DONE cycle
    do_op(16'h8001, 4'd4, 2'b01, 1'b0, 16'h0800, "pre_done_hold", 0);
    launch(16'h00F0, 4'd4, 2'b01, 1'b0, 0);
    wait_done(16'h000F, "done_hold");

    // Asynchronous reset during STG2
    wait_idle();
    launch(16'hBEEF, 4'd5, 2'b10, 1'b0, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(Out), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 32'(busy || done), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(2) == 0);
      In = N'($urandom); Cnt = C'($urandom); Op = 2'($urandom); Fill = 1'($urandom);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_right_shift.md
Name: seq_right_shift

Overview:
Multi-cycle right shifter, the right-direction counterpart to the datapath left shifter. Supports rotate right, logical right, arithmetic right and explicit-fill right shifts by 0 to 2^C-1 positions. Processes one binary shift stage (1, 2, 4, 8, ...) per clock behind a start/busy/done handshake. Serves ALU shift instructions where a multi-cycle, area-light shifter is acceptable.

Parameters:
N, 16, data width in bits
C, 4, shift-count width; number of stages; N must equal 2^C

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only when the block can accept (IDLE or DONE)
In  input  N  operand
Cnt  input  C  shift amount, 0..2^C-1
Op  input  2  00 rotate right, 01 logical right, 10 arithmetic right, 11 right with Fill
Fill  input  1  fill bit, used only when Op=11
busy  output  1  high while a shift is in progress
done  output  1  one-cycle pulse: Out holds a new result
Out  output  N  result register; holds its value until the next completion

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- rst_n low, at any time including mid-operation:
  - state <= IDLE; busy=0, done=0, Out=0; working registers cleared.
  - No done pulse for the aborted operation.
- States: IDLE, STG0..STG(C-1), DONE.
- IDLE:
  - If start=1 at a clk edge: latch In into work, latch Cnt, Op and Fill into internal registers, and latch fillbit.
  - fillbit = 0 for Op=01, In[N-1] for Op=10, Fill for Op=11; unused for Op=00.
  - Go to STG0.
- STGk, k=0..C-1, busy=1:
  - At the edge, if Cnt_q[k]=1, work <= work shifted right by 2^k.
  - Op 00: bits shifted out of the LSB end re-enter at the MSB end.
  - Other ops: the vacated 2^k MSBs take fillbit.
  - If Cnt_q[k]=0, work is unchanged.
  - Go to STG(k+1). From STG(C-1), go to DONE and load Out with the final shifted value.
- DONE: busy=0, done=1 for exactly one cycle.
  - If start=1, accept a new operation exactly as in IDLE and go to STG0. Done still pulses this cycle.
  - Otherwise go to IDLE.
- Latency:
  - start sampled at edge t0; stages applied at edges t1..tC.
  - Out valid and done=1 in the cycle after edge tC (C cycles after the start edge).
  - Latency is fixed and does not depend on Cnt; Cnt=0 still takes C cycles and returns In.
- start while busy=1 is ignored; it is neither queued nor latched.
- In, Cnt, Op and Fill may change freely after the start edge. Only the latched copies are used.
- Arithmetic fill uses the MSB of the latched operand, not the partially shifted work value. The two are identical by construction.
- Out changes only on the DONE transition or on reset.
- busy and done are never high in the same cycle.

Test Plan:
- Logical right: Op=01, In=16'h8001, Cnt=4, start at t0 -> busy high for 4 cycles; done=1 and Out=16'h0800 in the cycle after t4.
- Arithmetic right: Op=10, In=16'h8000, Cnt=15 -> Out=16'hFFFF. Then In=16'h7FF0, Cnt=4 -> Out=16'h07FF.
- Rotate right, edge counts:
  - Op=00, In=16'h0001, Cnt=1 -> Out=16'h8000.
  - Op=00, In=16'hA5A5, Cnt=0 -> Out=16'hA5A5 after the full 4-cycle latency.
  - Op=00, In=16'h1234, Cnt=8 -> Out=16'h3412.
- Explicit fill: Op=11, Fill=1, In=16'h0000, Cnt=8 -> Out=16'hFF00. Then Fill=0, In=16'hFFFF, Cnt=12 -> Out=16'h000F.
- Handshake:
  - start pulsed again during STG1 with different In -> ignored; the first result completes unchanged.
  - start held high in the DONE cycle with In=16'h00F0, Op=01, Cnt=4 -> done pulses once, the new op is accepted, and Out=16'h000F four cycles later.
- Reset mid-operation: rst_n driven low asynchronously (between clk edges) during STG2 -> busy, done and Out go to 0 immediately. No done pulse follows. After rst_n rises, the block sits in IDLE until the next start.
